pong_match_controller: RTL and testbench
========================================

Name: pong_match_controller

Overview:
- Match-level sequencer for the Pong display path: tracks scores, times serves and point pauses, and decides when a match ends.
- Drives the registered loss flags (lossA/lossB) consumed by the game-over checker renderer, plus play-enable and serve strobes for the ball/paddle logic.
- All timing is counted in frames, using a one-cycle frame tick from the VGA timing generator.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..(2^SCORE_W - 1).
- SCORE_W, 4, width of each score register.
- SERVE_DELAY_FRAMES, 60, frames between entering SERVE_WAIT and the serve strobe; must be >= 1.
- GAMEOVER_FRAMES, 300, frames the game-over screen is held before returning to IDLE.
- BLINK_FRAMES, 16, frames per half-period of the game-over blink output.
- CNT_W, 9, frame counter width; must hold max(SERVE_DELAY_FRAMES, GAMEOVER_FRAMES).

Ports:
- clk  in  1  system/pixel clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per frame; synchronous to clk.
- start  in  1  synchronous, debounced start request, sampled each cycle.
- miss_a  in  1  one-cycle pulse: ball passed player A's edge.
- miss_b  in  1  one-cycle pulse: ball passed player B's edge.
- score_a  out  SCORE_W  player A score.
- score_b  out  SCORE_W  player B score.
- play_en  out  1  high while the ball is live.
- serve_req  out  1  one-cycle strobe that launches the ball.
- serve_dir  out  1  launch direction: 0 = toward A, 1 = toward B.
- lossA  out  1  player A lost the match; held for the whole GAMEOVER state.
- lossB  out  1  player B lost the match; held for the whole GAMEOVER state.
- blink  out  1  game-over flash phase; 0 outside GAMEOVER.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, frame counter cnt 0, blink counter 0. Takes effect immediately, including mid-serve, mid-play or mid-game-over.
- All outputs registered; every state transition takes effect one clk after the qualifying input.
- States: IDLE, SERVE_WAIT, PLAY, GAMEOVER.
- IDLE:
  - play_en=0; scores keep their last values.
  - start=1: scores cleared to 0, serve_dir=0, cnt=0, go SERVE_WAIT.
- SERVE_WAIT:
  - play_en=0.
  - Each frame_tick increments cnt.
  - On the frame_tick where cnt==SERVE_DELAY_FRAMES-1: serve_req=1 for exactly one cycle, play_en=1 in the same cycle, go PLAY, cnt=0.
  - start, miss_a and miss_b are ignored.
- PLAY:
  - play_en=1.
  - miss_a alone: score_b increments, serve_dir=0 (loser receives), play_en drops next cycle.
    - If new score_b==WIN_SCORE: go GAMEOVER, lossA=1.
    - Else: go SERVE_WAIT, cnt=0.
  - miss_b alone: symmetric; score_a increments, serve_dir=1; if new score_a==WIN_SCORE, lossB=1.
  - miss_a and miss_b in the same cycle: no score change, serve_dir unchanged, go SERVE_WAIT (replay point).
  - start is ignored.
  - A miss coinciding with frame_tick is processed normally; the tick is not counted.
- GAMEOVER:
  - play_en=0. Exactly one of lossA/lossB is 1; they are never both 1.
  - Scores frozen; no score ever exceeds WIN_SCORE.
  - Each frame_tick increments cnt.
  - blink toggles every BLINK_FRAMES frame ticks, starting at 0 on entry.
  - On the frame_tick where cnt==GAMEOVER_FRAMES-1: go IDLE; lossA, lossB and blink are cleared; scores are retained for display.
  - start=1 (any cycle): same action as start in IDLE (scores cleared, loss flags cleared, go SERVE_WAIT).
  - If start and the final frame_tick coincide, start wins.
  - miss_a and miss_b are ignored.
- Arithmetic:
  - Score increment is plain SCORE_W-bit addition; it cannot wrap given the legal WIN_SCORE range.
  - cnt is compared for equality only. The blink counter is a separate counter of width clog2(BLINK_FRAMES)+1.
- Outputs must be glitch-free registers. Loss flags feed the pixel path directly and must not change mid-frame except via reset or start.

Test Plan:
- Reset mid-PLAY (WIN_SCORE=3, SERVE_DELAY_FRAMES=2): assert rst_n=0 while score_a=2 -> all outputs 0 asynchronously; state IDLE after release.
- start, then 2 frame_ticks -> exactly one serve_req pulse on the 2nd tick; play_en=1 from that cycle; serve_dir=0.
- In PLAY, miss_b x3 with serves between (WIN_SCORE=3) -> score_a 1,2,3; after the 3rd, lossB=1, lossA=0, play_en=0, serve_req never pulses again.
- In GAMEOVER (GAMEOVER_FRAMES=8, BLINK_FRAMES=2) -> blink sequence 0,0,1,1,0,0,1,1 across ticks; on the 8th tick lossB=0 and state is IDLE; score_a stays 3.
- miss_a and miss_b in the same cycle with scores 1:1 -> scores stay 1:1, serve_dir unchanged, next serve_req after SERVE_DELAY_FRAMES ticks.
- start in GAMEOVER coinciding with the final frame_tick -> scores 0:0, loss flags 0, state SERVE_WAIT; miss pulses in SERVE_WAIT cause no score change.

Source files
------------

// File: rtl/pong_match_controller.sv
// Match sequencer for the Pong display path: scores, serve timing,
// game-over hold/blink, and the registered loss flags for the renderer.
module pong_match_controller #(
    parameter int WIN_SCORE          = 7,
    parameter int SCORE_W            = 4,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int GAMEOVER_FRAMES    = 300,
    parameter int BLINK_FRAMES       = 16,
    parameter int CNT_W              = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               miss_a,
    input  logic               miss_b,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               play_en,
    output logic               serve_req,
    output logic               serve_dir,
    output logic               lossA,
    output logic               lossB,
    output logic               blink
);

    localparam int BLINK_W = $clog2(BLINK_FRAMES) + 1;
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(GAMEOVER_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, SERVE_WAIT, PLAY, GAMEOVER} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_next;
    logic [SCORE_W-1:0] score_a_next, score_b_next, inc_a, inc_b;
    logic               play_en_next, serve_req_next, serve_dir_next;
    logic               loss_a_next, loss_b_next, blink_next;

    assign inc_a = score_a + SCORE_W'(1);
    assign inc_b = score_b + SCORE_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            blink_cnt <= '0;
            score_a   <= '0;
            score_b   <= '0;
            play_en   <= 1'b0;
            serve_req <= 1'b0;
            serve_dir <= 1'b0;
            lossA     <= 1'b0;
            lossB     <= 1'b0;
            blink     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            blink_cnt <= blink_cnt_next;
            score_a   <= score_a_next;
            score_b   <= score_b_next;
            play_en   <= play_en_next;
            serve_req <= serve_req_next;
            serve_dir <= serve_dir_next;
            lossA     <= loss_a_next;
            lossB     <= loss_b_next;
            blink     <= blink_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        blink_cnt_next = blink_cnt;
        score_a_next   = score_a;
        score_b_next   = score_b;
        play_en_next   = play_en;
        serve_req_next = 1'b0;
        serve_dir_next = serve_dir;
        loss_a_next    = lossA;
        loss_b_next    = lossB;
        blink_next     = blink;

        unique case (state)
            IDLE: begin
                play_en_next = 1'b0;
                if (start) begin
                    score_a_next   = '0;
                    score_b_next   = '0;
                    serve_dir_next = 1'b0;
                    cnt_next       = '0;
                    state_next     = SERVE_WAIT;
                end
            end
            SERVE_WAIT: begin
                play_en_next = 1'b0;
                if (frame_tick) begin
                    if (cnt == SERVE_LAST) begin
                        serve_req_next = 1'b1;
                        play_en_next   = 1'b1;
                        cnt_next       = '0;
                        state_next     = PLAY;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            PLAY: begin
                play_en_next = 1'b1;
                if (miss_a || miss_b) begin
                    play_en_next   = 1'b0;
                    cnt_next       = '0;
                    blink_cnt_next = '0;
                    blink_next     = 1'b0;
                    state_next     = SERVE_WAIT;
                    // Simultaneous misses replay the point with no score change.
                    if (miss_a && !miss_b) begin
                        score_b_next   = inc_b;
                        serve_dir_next = 1'b0;
                        if (inc_b == WIN) begin
                            loss_a_next = 1'b1;
                            state_next  = GAMEOVER;
                        end
                    end else if (miss_b && !miss_a) begin
                        score_a_next   = inc_a;
                        serve_dir_next = 1'b1;
                        if (inc_a == WIN) begin
                            loss_b_next = 1'b1;
                            state_next  = GAMEOVER;
                        end
                    end
                end
            end
            GAMEOVER: begin
                play_en_next = 1'b0;
                // A start request outranks the final hold tick.
                if (start) begin
                    score_a_next   = '0;
                    score_b_next   = '0;
                    serve_dir_next = 1'b0;
                    loss_a_next    = 1'b0;
                    loss_b_next    = 1'b0;
                    blink_next     = 1'b0;
                    blink_cnt_next = '0;
                    cnt_next       = '0;
                    state_next     = SERVE_WAIT;
                end else if (frame_tick) begin
                    if (cnt == OVER_LAST) begin
                        loss_a_next    = 1'b0;
                        loss_b_next    = 1'b0;
                        blink_next     = 1'b0;
                        blink_cnt_next = '0;
                        cnt_next       = '0;
                        state_next     = IDLE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt_next = '0;
                            blink_next     = ~blink;
                        end else begin
                            blink_cnt_next = blink_cnt + BLINK_W'(1);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pong_match_controller.sv
// Scoreboard bench for pong_match_controller: directed match scenarios plus
// random play, checked against a frame-counting match model.
module tb_pong_match_controller;

    localparam int WIN = 3;
    localparam int SCW = 4;
    localparam int SD  = 2;
    localparam int GOF = 8;
    localparam int BL  = 2;
    localparam int CW  = 4;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_OVER  = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           frame_tick = 1'b0;
    logic           start = 1'b0;
    logic           miss_a = 1'b0;
    logic           miss_b = 1'b0;
    logic [SCW-1:0] score_a, score_b;
    logic           play_en, serve_req, serve_dir, lossA, lossB, blink;

    typedef struct packed {
        logic [SCW-1:0] sa;
        logic [SCW-1:0] sb;
        logic           pe;
        logic           sr;
        logic           dir;
        logic           la;
        logic           lb;
        logic           bl;
    } out_t;

    out_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int m_phase, m_sa, m_sb, m_frames;
    bit m_dir, m_lossA, m_lossB, m_serve;

    pong_match_controller #(
        .WIN_SCORE(WIN), .SCORE_W(SCW), .SERVE_DELAY_FRAMES(SD),
        .GAMEOVER_FRAMES(GOF), .BLINK_FRAMES(BL), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
        .miss_a(miss_a), .miss_b(miss_b), .score_a(score_a), .score_b(score_b),
        .play_en(play_en), .serve_req(serve_req), .serve_dir(serve_dir),
        .lossA(lossA), .lossB(lossB), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = P_IDLE; m_sa = 0; m_sb = 0; m_frames = 0;
        m_dir = 0; m_lossA = 0; m_lossB = 0; m_serve = 0;
    endtask

    task automatic model_new_match();
        m_sa = 0; m_sb = 0; m_dir = 0; m_frames = 0;
        m_lossA = 0; m_lossB = 0; m_phase = P_SERVE;
    endtask

    task automatic model_step(input bit st, input bit tk, input bit ma, input bit mb);
        m_serve = 0;
        case (m_phase)
            P_IDLE: if (st) model_new_match();
            P_SERVE: if (tk) begin
                m_frames++;
                if (m_frames == SD) begin
                    m_serve = 1;
                    m_phase = P_PLAY;
                end
            end
            P_PLAY: begin
                if (ma && mb) begin
                    m_phase = P_SERVE; m_frames = 0;
                end else if (ma) begin
                    m_sb++; m_dir = 0; m_frames = 0;
                    if (m_sb == WIN) begin m_phase = P_OVER; m_lossA = 1; end
                    else m_phase = P_SERVE;
                end else if (mb) begin
                    m_sa++; m_dir = 1; m_frames = 0;
                    if (m_sa == WIN) begin m_phase = P_OVER; m_lossB = 1; end
                    else m_phase = P_SERVE;
                end
            end
            default: begin
                if (st) model_new_match();
                else if (tk) begin
                    m_frames++;
                    if (m_frames == GOF) begin
                        m_phase = P_IDLE; m_lossA = 0; m_lossB = 0;
                    end
                end
            end
        endcase
    endtask

    function automatic out_t model_outputs();
        out_t o;
        o.sa  = SCW'(m_sa);
        o.sb  = SCW'(m_sb);
        o.pe  = (m_phase == P_PLAY);
        o.sr  = m_serve;
        o.dir = m_dir;
        o.la  = m_lossA;
        o.lb  = m_lossB;
        o.bl  = (m_phase == P_OVER) && (((m_frames / BL) % 2) == 1);
        return o;
    endfunction

    function automatic out_t dut_outputs();
        out_t o;
        o = {score_a, score_b, play_en, serve_req, serve_dir, lossA, lossB, blink};
        return o;
    endfunction

    task automatic checkOutput(input string name, input out_t act, input out_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got sa=%0d sb=%0d pe=%b sr=%b dir=%b la=%b lb=%b bl=%b, expected sa=%0d sb=%0d pe=%b sr=%b dir=%b la=%b lb=%b bl=%b",
                     name, $time, act.sa, act.sb, act.pe, act.sr, act.dir, act.la, act.lb, act.bl,
                     exp.sa, exp.sb, exp.pe, exp.sr, exp.dir, exp.la, exp.lb, exp.bl);
        end
    endtask

    task automatic checkField(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit tk, input bit ma, input bit mb);
        @(negedge clk);
        start = st; frame_tick = tk; miss_a = ma; miss_b = mb;
        model_step(st, tk, ma, mb);
        exp_q.push_back(model_outputs());
    endtask

    task automatic applyReset(input int hold);
        @(negedge clk);
        rst_n = 1'b0;
        start = 0; frame_tick = 0; miss_a = 0; miss_b = 0;
        model_reset();
        #1 checkOutput("async_reset", dut_outputs(), model_outputs());
        exp_q.push_back(model_outputs());
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            exp_q.push_back(model_outputs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_step(0, 0, 0, 0);
        exp_q.push_back(model_outputs());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic serve_ticks();
        for (int i = 0; i < SD; i++) applyStimulus(0, 1, 0, 0);
    endtask

    // Monitor: one expected snapshot per clock edge, popped just after the edge.
    always @(posedge clk) begin
        out_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("cycle", dut_outputs(), e);
        end
    end

    initial begin
        bit blink_exp[8];
        blink_exp = '{0, 0, 1, 1, 0, 0, 1, 1};
        model_reset();
        applyReset(2);

        // Build a 2:0 lead in PLAY, then reset mid-point.
        applyStimulus(1, 0, 0, 0);
        serve_ticks();
        settle();
        checkField("first_serve_req", serve_req, 1);
        checkField("first_serve_play_en", play_en, 1);
        checkField("first_serve_dir", serve_dir, 0);
        applyStimulus(0, 0, 0, 1); serve_ticks();
        applyStimulus(0, 0, 0, 1); serve_ticks();
        settle();
        checkField("score_a_before_reset", score_a, 2);
        applyReset(3);

        // Player A wins 3:0.
        applyStimulus(1, 0, 0, 0); serve_ticks();
        applyStimulus(0, 0, 0, 1); serve_ticks();
        applyStimulus(0, 0, 0, 1); serve_ticks();
        applyStimulus(0, 0, 0, 1);
        settle();
        checkField("win_score_a", score_a, 3);
        checkField("win_lossB", lossB, 1);
        checkField("win_lossA", lossA, 0);
        checkField("win_play_en", play_en, 0);
        for (int k = 0; k < GOF; k++) begin
            checkField("gameover_blink", blink, int'(blink_exp[k]));
            applyStimulus(0, 1, 0, 0);
            settle();
        end
        checkField("hold_end_lossB", lossB, 0);
        checkField("hold_end_score_a", score_a, 3);

        // Replay point at 1:1 keeps scores and serve direction.
        applyStimulus(1, 0, 0, 0); serve_ticks();
        applyStimulus(0, 0, 1, 0); serve_ticks();
        applyStimulus(0, 0, 0, 1); serve_ticks();
        applyStimulus(0, 0, 1, 1);
        settle();
        checkField("replay_score_a", score_a, 1);
        checkField("replay_score_b", score_b, 1);
        checkField("replay_dir", serve_dir, 1);
        applyStimulus(0, 1, 0, 0);
        settle();
        checkField("replay_no_early_serve", serve_req, 0);
        applyStimulus(0, 1, 0, 0);
        settle();
        checkField("replay_serve", serve_req, 1);

        // B wins, then start collides with the final hold tick.
        applyStimulus(0, 0, 1, 0); serve_ticks();
        applyStimulus(0, 0, 1, 0);
        settle();
        checkField("b_win_lossA", lossA, 1);
        for (int k = 0; k < GOF - 1; k++) applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        settle();
        checkField("restart_score_b", score_b, 0);
        checkField("restart_lossA", lossA, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1);
        settle();
        checkField("serve_wait_ignores_miss", score_a + score_b, 0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) applyReset(int'($urandom_range(1, 3)));
            else applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
        applyStimulus(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        checkField("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
